// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// hrm_mem_pkg : shared port indices and default widths for the data memory.
// Rev 1.0
// ============================================================================
package hrm_mem_pkg;

  localparam bit PORT_CPU   = 1'b0;
  localparam bit PORT_DBG   = 1'b1;

  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 8;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arb_port_if / mem_arb_mem_if : requester-side and memory-side buses.
// Rev 1.0
// ============================================================================
interface mem_arb_port_if
  import hrm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int ADDR_WIDTH = MEM_ADDR_W
);
  logic                  req;
  logic                  we;
  logic                  mmio;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, mmio, addr, din, input gnt, rvalid, rdata);
  modport slave  (input req, we, mmio, addr, din, output gnt, rvalid, rdata);
endinterface

interface mem_arb_mem_if
  import hrm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int ADDR_WIDTH = MEM_ADDR_W
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  we;
  logic                  mmio;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output addr, din, we, mmio, input dout);
  modport slave  (input addr, din, we, mmio, output dout);
endinterface
`default_nettype wire

// File: rtl/mem_resp_reg.sv
`default_nettype none
// ============================================================================
// mem_resp_reg : per-port read response; rdata follows live data while valid
// and holds the last returned value otherwise. Rev 1.0
// ============================================================================
module mem_resp_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (valid) begin
      r_hold <= data;
    end
  end

  // Memory data is only present during the response cycle, so it is passed
  // straight through then and captured for the idle cycles that follow.
  assign rvalid = valid;
  assign rdata  = valid ? data : r_hold;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fixed-priority CPU/debug arbiter for the data memory with a
// bounded-streak starvation guard for the debug port. Rev 1.0
// ============================================================================
module mem_arbiter
  import hrm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arb_port_if.slave p0,
  mem_arb_port_if.slave p1,
  mem_arb_mem_if.master mem
);

  localparam logic [3:0] c_max_streak = 4'(MAX_STREAK);

  logic [3:0]            r_streak;
  logic                  r_rd_pend;
  logic                  r_rd_port;
  logic                  r_rd_mmio;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;
  logic                  w_we;
  logic                  w_mmio;
  logic                  w_rd_start;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Port 1 takes the slot once port 0 has used up its streak allowance.
  always_comb begin
    w_gnt1 = rst_n && p1.req && (!p0.req || (r_streak == c_max_streak));
    w_gnt0 = rst_n && p0.req && !w_gnt1;
  end

  assign p0.gnt = w_gnt0;
  assign p1.gnt = w_gnt1;

  always_comb begin
    w_addr = '0;
    w_din  = '0;
    w_we   = 1'b0;
    w_mmio = 1'b0;
    if (w_gnt1) begin
      w_addr = p1.addr;
      w_din  = p1.din;
      w_we   = p1.we;
      w_mmio = p1.mmio;
    end else if (w_gnt0) begin
      w_addr = p0.addr;
      w_din  = p0.din;
      w_we   = p0.we;
      w_mmio = p0.mmio;
    end
  end

  assign mem.addr   = w_addr;
  assign mem.din    = w_din;
  assign mem.we     = w_we;
  assign mem.mmio   = w_mmio;
  assign w_rd_start = (w_gnt0 || w_gnt1) && !w_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= 4'd0;
    end else if (w_gnt1 || !p1.req) begin
      r_streak <= 4'd0;
    end else if (w_gnt0 && (r_streak != c_max_streak)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_port <= PORT_CPU;
      r_rd_mmio <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_start;
      if (w_rd_start) begin
        r_rd_port <= w_gnt1;
        r_rd_mmio <= w_mmio;
      end
    end
  end

  // MMIO reads are not backed by RAM data, so they return zero.
  assign w_rdata = r_rd_mmio ? '0 : mem.dout;

  mem_resp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_resp_p0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (r_rd_pend && (r_rd_port == PORT_CPU)),
    .data   (w_rdata),
    .rvalid (p0.rvalid),
    .rdata  (p0.rdata)
  );

  mem_resp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_resp_p1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (r_rd_pend && (r_rd_port == PORT_DBG)),
    .data   (w_rdata),
    .rvalid (p1.rvalid),
    .rdata  (p1.rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed scoreboard bench for mem_arbiter. Rev 1.0
// ============================================================================
module tb_mem_arbiter;
  import hrm_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arb_port_if p0 ();
  mem_arb_port_if p1 ();
  mem_arb_mem_if  mem ();

  mem_arbiter #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .MAX_STREAK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p0    (p0),
    .p1    (p1),
    .mem   (mem)
  );

  // Memory model: registered read, MMIO reads return a non-zero marker.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 16) ? 8'h5A : ~8'(i);
    end else if (mem.we && !mem.mmio) begin
      ram[mem.addr] <= mem.din;
    end
    mem.dout <= mem.mmio ? 8'hEE : ram[mem.addr];
  end

  // Protocol: a waiting request must keep we/mmio/addr stable.
  logic       hold0, hold1;
  logic [9:0] snap0, snap1;
  always @(posedge clk) begin
    if (rst_n && hold0 && p0.req)
      assert ({p0.we, p0.mmio, p0.addr} == snap0) else $error("protocol: port 0 request changed before grant");
    if (rst_n && hold1 && p1.req)
      assert ({p1.we, p1.mmio, p1.addr} == snap1) else $error("protocol: port 1 request changed before grant");
    hold0 <= p0.req && !p0.gnt;
    hold1 <= p1.req && !p1.gnt;
    snap0 <= {p0.we, p0.mmio, p0.addr};
    snap1 <= {p1.we, p1.mmio, p1.addr};
  end

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every read response is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (p0.rvalid || p1.rvalid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'({p0.rvalid, p1.rvalid}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_port", 32'({p0.rvalid, p1.rvalid}), e.port ? 32'h1 : 32'h2);
        check("rdata", 32'(e.port ? p1.rdata : p0.rdata), 32'(e.data));
      end
    end
  end

  task automatic drive(input bit port, input logic req, input logic we, input logic mmio,
                       input logic [7:0] addr, input logic [7:0] din);
    if (port) begin
      p1.req = req; p1.we = we; p1.mmio = mmio; p1.addr = addr; p1.din = din;
    end else begin
      p0.req = req; p0.we = we; p0.mmio = mmio; p0.addr = addr; p0.din = din;
    end
  endtask

  task automatic idle(input bit port);
    drive(port, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h99);
    idle(1);
    @(negedge clk);
    check("reset_gnt", 32'({p0.gnt, p1.gnt}), 32'd0);
    check("reset_mem_we", 32'(mem.we), 32'd0);
    check("reset_rvalid", 32'({p0.rvalid, p1.rvalid}), 32'd0);
    check("reset_rdata", 32'({p0.rdata, p1.rdata}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0);
    step();

    // Solo port 0 read of 0x10
    drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    push(1'b0, 8'h5A);
    @(negedge clk);
    check("solo_gnt", 32'({p0.gnt, p1.gnt}), 32'h2);
    check("solo_addr", 32'(mem.addr), 32'h10);
    check("solo_we", 32'(mem.we), 32'd0);
    step();
    idle(0);
    step();
    @(negedge clk);
    check("p0_rdata_hold", 32'({p0.rvalid, p0.rdata}), 32'h05A);
    step();

    // Port 1 write then read back
    drive(1, 1'b1, 1'b1, 1'b0, 8'h20, 8'hC3);
    @(negedge clk);
    check("wr_gnt", 32'({p1.gnt, mem.we}), 32'h3);
    check("wr_bus", 32'({mem.addr, mem.din}), 32'h20C3);
    step();
    drive(1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    push(1'b1, 8'hC3);
    @(negedge clk);
    check("rd_gnt", 32'({p1.gnt, mem.we}), 32'h2);
    step();
    idle(1);
    step();

    // Continuous contention: P0,P0,P0,P0,P1 repeating
    drive(0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h31, 8'h00);
    for (int c = 0; c < 10; c++) begin
      logic exp_p1;
      exp_p1 = (c == 4) || (c == 9);
      push(exp_p1, exp_p1 ? 8'hCE : 8'hCF);
      @(negedge clk);
      check("contention_gnt", 32'({p0.gnt, p1.gnt}), exp_p1 ? 32'h1 : 32'h2);
      step();
    end
    idle(0);
    idle(1);
    step();
    step();

    // MMIO read returns zero
    drive(0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
    push(1'b0, 8'h00);
    @(negedge clk);
    check("mmio_gnt", 32'({p0.gnt, mem.mmio}), 32'h3);
    step();
    idle(0);
    step();

    // Reset during a pending port 1 read drops the response
    drive(1, 1'b1, 1'b0, 1'b0, 8'h41, 8'h00);
    @(negedge clk);
    check("rst_rd_gnt", 32'(p1.gnt), 32'd1);
    #1;
    rst_n = 1'b0;
    idle(1);
    step();
    @(negedge clk);
    check("rst_drop_rvalid", 32'({p1.rvalid, p1.rdata}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 1'b1, 1'b0, 1'b0, 8'h42, 8'h00);
    push(1'b1, 8'hBD);
    @(negedge clk);
    check("post_rst_gnt", 32'({p0.gnt, p1.gnt}), 32'h1);
    step();
    idle(1);
    step();

    // Streak built to 3, then reset: arbitration must start from a fresh streak
    drive(0, 1'b1, 1'b1, 1'b0, 8'h50, 8'h11);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h43, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("streak_build_gnt", 32'({p0.gnt, p1.gnt}), 32'h2);
      if (c < 3) step();
    end
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) push(1'b1, 8'hBC);
      @(negedge clk);
      check("fresh_streak_gnt", 32'({p0.gnt, p1.gnt}), (c == 4) ? 32'h1 : 32'h2);
      step();
    end
    idle(0);
    idle(1);
    repeat (3) step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
